// File: rtl/enum_rr_arbiter.sv
// ---------------------------------------------------------------------------
// enum_rr_arbiter
//
// Four-requester round-robin arbiter.
// - An owner holds the shared resource for at most MAX_HOLD consecutive
//   cycles.
// - Ownership ends early when the owner drops its request.
// - Every ownership is followed by a RELEASE cycle and an IDLE cycle.
// - The search start pointer moves past the last owner in the RELEASE cycle.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles per ownership (1..8).
//
// Ports
//   clk     in   1  single clock; all state changes on posedge clk
//   rst     in   1  synchronous, active-high reset
//   req     in   4  request vector; bit i = requester i wants the resource
//   gnt     out  4  grant vector; one-hot(owner) in GRANT/HOLD, else zero
//   owner   out  2  index of the current or most recent owner
//   busy    out  1  high whenever the FSM is not in ST_IDLE
//   state_o out  2  encoded FSM state
//                   (0 IDLE, 1 GRANT, 2 HOLD, 3 RELEASE)
//
// The companion module enum_rr_arbiter_chk holds the immediate assertions.
// ---------------------------------------------------------------------------

module enum_rr_arbiter_chk #(
  parameter int MAX_HOLD = 4
) (
  input logic       rst,
  input logic [3:0] gnt,
  input logic [1:0] state,
  input logic [2:0] hold_cnt,
  input logic [1:0] idle_code
);

  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  // Structural invariants, checked continuously outside reset.
  always_comb begin
    assert (rst || $onehot0(gnt));
    assert (rst || ((gnt != 4'b0000) == ((state == 2'd1) || (state == 2'd2))));
    assert (rst || (hold_cnt <= HOLD_LAST));
    assert (idle_code == 2'h0);
  end

endmodule

module enum_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Last hold_cnt value before ownership is forcibly ended.
  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [1:0] owner_r;
  logic [2:0] hold_cnt_r;
  logic [1:0] pick_s;
  logic       owner_done_s;

  // First requester found when scanning from p upward (mod 4).
  // The scan runs from the farthest offset down to offset 0,
  // so the nearest set bit overwrites any farther one.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Round-robin winner and end-of-ownership decision.
  always_comb begin
    pick_s       = rr_pick(req, ptr_r);
    owner_done_s = (req[owner_r] == 1'b0) || (hold_cnt_r == HOLD_LAST);
  end

  // Arbiter FSM together with its pointer, owner and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 2'd0;
      owner_r    <= 2'd0;
      hold_cnt_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            owner_r    <= pick_s;
            hold_cnt_r <= 3'd0;
            state_r    <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT, ST_HOLD: begin
          if (owner_done_s) begin
            state_r <= ST_RELEASE;
          end else begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= hold_cnt_r + 3'd1;
          end
        end
        ST_RELEASE: begin
          ptr_r   <= owner_r + 2'd1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; the grant is live only while owning.
  always_comb begin
    gnt = 4'b0000;
    case (state_r)
      ST_GRANT, ST_HOLD: gnt = onehot4(owner_r);
      default:           gnt = 4'b0000;
    endcase
    owner   = owner_r;
    busy    = (state_r != ST_IDLE);
    state_o = state_r;
  end

  enum_rr_arbiter_chk #(
    .MAX_HOLD (MAX_HOLD)
  ) u_chk (
    .rst       (rst),
    .gnt       (gnt),
    .state     (state_r),
    .hold_cnt  (hold_cnt_r),
    .idle_code (ST_IDLE)
  );

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Scoreboard bench for enum_rr_arbiter.
// - Two instances run side by side on the same stimulus:
//     a: MAX_HOLD = 4
//     b: MAX_HOLD = 1
// - The driver steps a transaction-level ownership model.
// - Each cycle it queues the expected {gnt, owner, busy, state} per instance.
// - A separate monitor pops and compares after every active edge.
module tb_enum_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] owner_a, owner_b, state_a, state_b;
  logic       busy_a, busy_b;

  enum_rr_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .owner(owner_a), .busy(busy_a), .state_o(state_a)
  );

  enum_rr_arbiter #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .owner(owner_b), .busy(busy_b), .state_o(state_b)
  );

  // Reference model state per instance.
  // - m_active : an ownership is in progress.
  // - m_used   : grant cycles already given in this ownership.
  // - m_rel    : the single release cycle after an ownership is running.
  int m_owner [2];
  int m_ptr   [2];
  int m_used  [2];
  bit m_active[2];
  bit m_rel   [2];
  int mh      [2];

  typedef logic [8:0] obs_t;   // {gnt[3:0], owner[1:0], busy, state[1:0]}
  obs_t q_a[$];
  obs_t q_b[$];

  int tests = 0;
  int fails = 0;

  // Advance model i by one clock edge at which (r, rq) is sampled.
  // Return the outputs expected during the following cycle.
  function automatic obs_t model_step(int i, logic r, logic [3:0] rq);
    logic [3:0] g;
    logic [1:0] st;
    logic       b;
    bit         found;
    if (r) begin
      m_active[i] = 1'b0; m_rel[i] = 1'b0;
      m_owner[i] = 0; m_ptr[i] = 0; m_used[i] = 0;
    end else if (m_rel[i]) begin
      m_rel[i] = 1'b0;
      m_ptr[i] = (m_owner[i] + 1) % 4;
    end else if (m_active[i]) begin
      if (!rq[m_owner[i]] || m_used[i] >= mh[i]) begin
        m_active[i] = 1'b0;
        m_rel[i]    = 1'b1;
      end else begin
        m_used[i] = m_used[i] + 1;
      end
    end else if (rq != 4'b0000) begin
      found = 1'b0;
      for (int off = 0; off < 4; off++) begin
        if (!found && rq[(m_ptr[i] + off) % 4]) begin
          found       = 1'b1;
          m_owner[i]  = (m_ptr[i] + off) % 4;
        end
      end
      m_active[i] = 1'b1;
      m_used[i]   = 1;
    end
    g  = m_active[i] ? 4'(1 << m_owner[i]) : 4'b0000;
    st = m_rel[i] ? 2'd3 : (m_active[i] ? ((m_used[i] == 1) ? 2'd1 : 2'd2) : 2'd0);
    b  = m_active[i] || m_rel[i];
    return {g, 2'(m_owner[i]), b, st};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: actual gnt=%b owner=%0d busy=%b state=%0d, expected gnt=%b owner=%0d busy=%b state=%0d",
               name, $time, act[8:5], act[4:3], act[2], act[1:0],
               exp[8:5], exp[4:3], exp[2], exp[1:0]);
    end
  endtask

  // Monitor: one queued expectation per instance is consumed after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) check("arb_mh4", {gnt_a, owner_a, busy_a, state_a}, q_a.pop_front());
      if (q_b.size() > 0) check("arb_mh1", {gnt_b, owner_b, busy_b, state_b}, q_b.pop_front());
    end
  end

  // Apply inputs for the next edge and queue what that edge should produce.
  task automatic drive(input logic r, input logic [3:0] rq, input int n);
    for (int c = 0; c < n; c++) begin
      rst = r;
      req = rq;
      q_a.push_back(model_step(0, r, rq));
      q_b.push_back(model_step(1, r, rq));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] rq;
    int         hold_left;
    mh[0] = 4;
    mh[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_ptr[i] = 0; m_used[i] = 0;
      m_active[i] = 1'b0; m_rel[i] = 1'b0;
    end
    rst = 1'b1;
    req = 4'hF;

    // Directed scenarios first.
    drive(1'b1, 4'hF,    2);   // reset with all requests pending
    drive(1'b0, 4'b0100, 8);   // single requester held: full hold, then release
    drive(1'b0, 4'b0000, 3);
    drive(1'b0, 4'hF,    30);  // all requesting: full rotation
    drive(1'b1, 4'hF,    2);
    drive(1'b0, 4'b0010, 1);   // one-cycle request
    drive(1'b0, 4'b0000, 4);
    drive(1'b1, 4'hF,    1);
    drive(1'b0, 4'b1000, 3);   // requester 3 granted, then into HOLD
    drive(1'b1, 4'b1000, 1);   // reset mid-ownership
    drive(1'b0, 4'b0110, 10);
    drive(1'b0, 4'b0011, 15);  // two requesters alternate

    // Randomised phase: request patterns held for short bursts, rare resets.
    hold_left = 0;
    rq = 4'b0000;
    for (int c = 0; c < 900; c++) begin
      if (hold_left == 0) begin
        rq        = 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 7);
      end
      hold_left--;
      drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, rq, 1);
    end

    drive(1'b0, 4'b0000, 3);
    @(posedge clk);
    #2;
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL drain: actual %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enum_rr_arbiter.md
ENUM_RR_ARBITER -- requirements
Module: enum_rr_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per ownership; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL have port: gnt  output  4  grant vector; one-hot or zero.
REQ-006 SHALL have port: owner  output  2  index of current/last owner.
REQ-007 SHALL have port: busy  output  1  high when state != ST_IDLE.
REQ-008 SHALL have port: state_o  output  2  encoded FSM state.

Function
REQ-009 SHALL hold FSM state in an enum typed logic [1:0]: ST_IDLE=0, ST_GRANT=1, ST_HOLD=2, ST_RELEASE=3; all four codes legal.
REQ-010 SHALL keep registers ptr[1:0] (round-robin start), owner[1:0] and hold_cnt[2:0].
REQ-011 SHALL, in ST_IDLE with req != 0, search ptr, ptr+1, ptr+2, ptr+3 (mod 4), latch the first set index into owner, clear hold_cnt and go to ST_GRANT.
REQ-012 SHALL stay in ST_IDLE, with owner/ptr unchanged, when req == 0.
REQ-013 SHALL, from ST_GRANT or ST_HOLD, go to ST_RELEASE when req[owner]==0 or hold_cnt==MAX_HOLD-1; otherwise go to ST_HOLD and increment hold_cnt.
REQ-014 SHALL, in ST_RELEASE, set ptr=owner+1 (mod 4, wraps 3->0) and go to ST_IDLE unconditionally.
REQ-015 SHALL drive gnt = one-hot(owner) combinationally in ST_GRANT and ST_HOLD, and 4'b0 in ST_IDLE and ST_RELEASE.
REQ-016 SHALL give latency: req sampled at edge t in ST_IDLE -> gnt high during cycle t+1.
REQ-017 SHALL assert gnt for min(cycles req[owner] stays high from grant, MAX_HOLD) cycles, minimum 1.
REQ-018 SHALL ignore changes to non-owner req bits while busy; they are arbitrated only in ST_IDLE.
REQ-019 SHALL give a minimum 2-cycle gnt-low gap (ST_RELEASE, ST_IDLE) between consecutive ownerships.
REQ-020 SHALL, when MAX_HOLD==1, always go ST_GRANT -> ST_RELEASE.
REQ-021 SHALL include immediate assertions in a combinational block: gnt is one-hot-or-zero; gnt!=0 iff state in {ST_GRANT, ST_HOLD}; hold_cnt <= MAX_HOLD-1; ST_IDLE encodes to 2'h0.

Reset
REQ-022 SHALL, when rst is high at an edge, set state=ST_IDLE, ptr=0, owner=0, hold_cnt=0, overriding all other transitions.
REQ-023 SHALL give reset output values gnt=4'h0, owner=2'h0, busy=0, state_o=2'h0.
REQ-024 SHALL, on rst asserted mid-ownership, drop gnt at the next cycle without passing through ST_RELEASE; ptr returns to 0.

Verification
REQ-025 SHALL cover: rst=1 for 2 cycles with req=4'hF -> gnt=0, state_o=0, busy=0 each cycle.
REQ-026 SHALL cover: after reset, req=4'b0100 held from edge t, MAX_HOLD=4 -> gnt=4'b0100 in cycles t+1..t+4; ST_RELEASE at t+5; ST_IDLE at t+6; ptr=3.
REQ-027 SHALL cover: req=4'hF continuous from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, each 4 cycles with 2 zero cycles between.
REQ-028 SHALL cover: req=4'b0010 for one cycle only -> gnt=4'b0010 for exactly 1 cycle, then ST_RELEASE, ptr=2.
REQ-029 SHALL cover: rst pulsed while gnt=4'b1000 in ST_HOLD, then req=4'b0110 -> gnt=0 next cycle; next grant is 4'b0010 (search from ptr=0).
REQ-030 SHALL cover: MAX_HOLD=1, req=4'b0011 held -> alternating single-cycle grants 0001, 0010, 0001, each separated by 2 zero cycles; no assertion fires in any scenario.
